// File: rtl/tristate_bus_arbiter.sv
// ============================================================================
// Module   : tristate_bus_arbiter
// Brief    : Round-robin owner selection for a shared tri-state bus. Outputs
//            are registered one-hot bufif1 enables, with an all-off gap
//            between successive owners.
//            Optional macro BUS_ARB_TIMEOUT_EN adds a MAX_HOLD tenure limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_bus_arbiter #(
  parameter int N          = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 bus_idle,
  output logic                 preempt
);

  localparam int OW = $clog2(N);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [OW-1:0] c_last_init = OW'(N - 1);
  localparam logic [TW-1:0] c_turn_last = TW'(TURNAROUND - 1);

  generate
    if (N < 2 || N > 8 || TURNAROUND < 1 || MAX_HOLD < 1) begin : g_bad_params
      $error("tristate_bus_arbiter: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic [TW-1:0]   r_turn_cnt;
  logic            r_bus_idle;
  logic            w_timeout;
  logic            w_release;

  // Winner is the lowest requester above r_last, else the lowest requester overall.
  logic [OW-1:0]   w_hi_idx;
  logic [OW-1:0]   w_lo_idx;
  logic            w_hi_found;
  logic [OW-1:0]   w_win_idx;
  logic [N-1:0]    w_win_onehot;

  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = OW'(i);
        if (OW'(i) > r_last) begin
          w_hi_idx   = OW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_win_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
    w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);

  logic [HW-1:0] r_hold_cnt;
  logic          r_preempt;

  assign w_timeout = req[r_owner] && (r_hold_cnt == c_max_hold);
  assign preempt   = r_preempt;
`else
  assign w_timeout = 1'b0;
  assign preempt   = 1'b0;
`endif

  assign w_release = !req[r_owner] || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_last     <= c_last_init;
      r_turn_cnt <= '0;
      r_bus_idle <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      r_preempt <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state    <= S_OWN;
            r_grant    <= w_win_onehot;
            r_owner    <= w_win_idx;
            r_bus_idle <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold_cnt <= HW'(1);
`endif
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_state    <= S_TURN;
            r_grant    <= '0;
            r_owner    <= '0;
            r_last     <= r_owner;
            r_turn_cnt <= '0;
            r_bus_idle <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_preempt  <= w_timeout;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
          end
        end
        S_TURN: begin
          if (r_turn_cnt == c_turn_last) begin
            r_state <= S_IDLE;
          end else begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign owner    = r_owner;
  assign bus_idle = r_bus_idle;

endmodule

`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
// ============================================================================
// Module   : tb_tristate_bus_arbiter
// Brief    : Cycle-vector bench for tristate_bus_arbiter with a shared 32-bit
//            tri-state bus driven by the grant enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int TA = 1;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  wire  [N-1:0] grant;
  wire  [1:0]   owner;
  wire          bus_idle;
  wire          preempt;

  tri   [31:0]  ad;
  logic [31:0]  agent_data [N];

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(N), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .owner    (owner),
    .bus_idle (bus_idle),
    .preempt  (preempt)
  );

  generate
    for (genvar a = 0; a < N; a++) begin : g_drv
      assign ad = grant[a] ? agent_data[a] : 32'bz;
    end
  endgenerate

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       idle;
    logic       preempt;
  } vec_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       idle;
    logic       preempt;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t V(input logic r, input logic [3:0] rq, input logic [3:0] g,
                             input logic [1:0] o, input logic i, input logic p);
    vec_t v;
    v = '{rst: r, req: rq, grant: g, owner: o, idle: i, preempt: p};
    return v;
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] o, input logic i, input logic p, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r;
    req = rq;
    sb.push_back(exp_t'{grant: g, owner: o, idle: i, preempt: p});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    got = {grant, owner, bus_idle, preempt};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got grant=%b owner=%0d idle=%b preempt=%b, want grant=%b owner=%0d idle=%b preempt=%b",
               tag, grant, owner, bus_idle, preempt, e.grant, e.owner, e.idle, e.preempt);
    end
    checks++;
    if ($countones(grant) > 1) begin
      errors++;
      $display("FAIL %s onehot: got grant=%b, want at most one bit set", tag, grant);
    end
    if (e.grant != 4'b0000) begin
      checks++;
      if (ad !== agent_data[e.owner]) begin
        errors++;
        $display("FAIL %s bus: got ad=%h, want %h", tag, ad, agent_data[e.owner]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    agent_data[0] = 32'h1111_1111;
    agent_data[1] = 32'haaaa_aaaa;
    agent_data[2] = 32'h3333_3333;
    agent_data[3] = 32'h4444_4444;

    // reset and a single requester
    vt.push_back(V(1, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(1, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0001, 4'b0001, 0, 0, 0));
    vt.push_back(V(0, 4'b0001, 4'b0001, 0, 0, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    // all four request, each releases after three grant cycles
    vt.push_back(V(1, 4'b0000, 4'b0000, 0, 1, 0));
    for (int k = 0; k < 3; k++) vt.push_back(V(0, 4'b1111, 4'b0001, 0, 0, 0));
    for (int k = 0; k < 2; k++) vt.push_back(V(0, 4'b1110, 4'b0000, 0, 1, 0));
    for (int k = 0; k < 3; k++) vt.push_back(V(0, 4'b1110, 4'b0010, 1, 0, 0));
    for (int k = 0; k < 2; k++) vt.push_back(V(0, 4'b1100, 4'b0000, 0, 1, 0));
    for (int k = 0; k < 3; k++) vt.push_back(V(0, 4'b1100, 4'b0100, 2, 0, 0));
    for (int k = 0; k < 2; k++) vt.push_back(V(0, 4'b1000, 4'b0000, 0, 1, 0));
    for (int k = 0; k < 3; k++) vt.push_back(V(0, 4'b1000, 4'b1000, 3, 0, 0));
    for (int k = 0; k < 2; k++) vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    // owner 2, then 0 and 3 arrive: 3 must come before 0
    vt.push_back(V(0, 4'b0100, 4'b0100, 2, 0, 0));
    vt.push_back(V(0, 4'b1101, 4'b0100, 2, 0, 0));
    vt.push_back(V(0, 4'b1101, 4'b0100, 2, 0, 0));
    vt.push_back(V(0, 4'b1001, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b1001, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b1001, 4'b1000, 3, 0, 0));
    vt.push_back(V(0, 4'b0001, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0001, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0001, 4'b0001, 0, 0, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    // reset while agent 1 drives, then restart from index 0
    vt.push_back(V(0, 4'b0010, 4'b0010, 1, 0, 0));
    vt.push_back(V(0, 4'b0010, 4'b0010, 1, 0, 0));
    vt.push_back(V(1, 4'b0011, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0011, 4'b0001, 0, 0, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));
    vt.push_back(V(0, 4'b0000, 4'b0000, 0, 1, 0));

    for (int k = 0; k < vt.size(); k++)
      step(vt[k].rst, vt[k].req, vt[k].grant, vt[k].owner, vt[k].idle, vt[k].preempt,
           $sformatf("vec%0d", k));

    step(1, 4'b0000, 4'b0000, 0, 1, 0, "hold_rst");
`ifdef BUS_ARB_TIMEOUT_EN
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int c = 0; c < MH; c++) step(0, 4'b0011, 4'b0001, 0, 0, 0, "to_own0");
      step(0, 4'b0011, 4'b0000, 0, 1, 1, "to_preempt0");
      step(0, 4'b0011, 4'b0000, 0, 1, 0, "to_gap0");
      for (int c = 0; c < MH; c++) step(0, 4'b0011, 4'b0010, 1, 0, 0, "to_own1");
      step(0, 4'b0011, 4'b0000, 0, 1, 1, "to_preempt1");
      step(0, 4'b0011, 4'b0000, 0, 1, 0, "to_gap1");
    end
    step(0, 4'b0011, 4'b0001, 0, 0, 0, "to_again0");
`else
    for (int c = 0; c < 120; c++) step(0, 4'b0011, 4'b0001, 0, 0, 0, "hold0");
`endif
    step(0, 4'b0000, 4'b0000, 0, 1, 0, "final_release");
    step(0, 4'b0000, 4'b0000, 0, 1, 0, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
